demux1to2_buffered: RTL and testbench
=====================================

DEMUX1TO2_BUFFERED -- requirements
Module: demux1to2_buffered

Interface
REQ-001 SHALL have parameter WIDTH, default 24, data path width in bits (CPU word size).
REQ-002 SHALL have parameter CNTW, default 8, width of per-port transfer counters.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port InData  input  WIDTH  word to be routed.
REQ-006 SHALL have port InSel  input  1  destination select: 0 -> port 0, 1 -> port 1.
REQ-007 SHALL have port InValid  input  1  InData/InSel valid this cycle.
REQ-008 SHALL have port InReady  output  1  block accepts the word this cycle.
REQ-009 SHALL have ports Out0Data / Out1Data  output  WIDTH  buffered word per port.
REQ-010 SHALL have ports Out0Valid / Out1Valid  output  1  port buffer holds a word.
REQ-011 SHALL have ports Out0Ready / Out1Ready  input  1  downstream consumes word.
REQ-012 SHALL have ports Count0 / Count1  output  CNTW  completed output transfers per port.

Function
REQ-013 SHALL keep one single-entry buffer per output port, each a two-state FSM: EMPTY (OutNValid=0) and FULL (OutNValid=1).
REQ-014 SHALL drive InReady combinationally = (selected port EMPTY) OR (selected port FULL AND its OutNReady=1); depends only on InSel, state, OutNReady, never on InValid.
REQ-015 SHALL accept a word when InValid=1 AND InReady=1; word and FSM update at the next rising edge (latency 1 cycle: OutNValid=1 the cycle after acceptance).
REQ-016 SHALL treat OutN transfer as OutNValid=1 AND OutNReady=1 at a rising edge.
REQ-017 SHALL transition EMPTY->FULL on accept to that port; FULL->EMPTY on transfer with no accept to that port; FULL->FULL with new data on simultaneous transfer and accept to the same port (no bubble).
REQ-018 SHALL hold OutNData and OutNValid stable while FULL and OutNReady=0; no word is dropped or duplicated.
REQ-019 SHALL leave the non-selected port's buffer unaffected by any input activity; both ports may transfer in the same cycle.
REQ-020 SHALL ignore InData/InSel when InValid=0 or InReady=0 (no state change).
REQ-021 SHALL register OutNData only on accept; OutNData value while EMPTY is don't-care but SHALL retain last loaded value.
REQ-022 SHALL increment CountN by 1 on each OutN transfer, modulo 2^CNTW (wrap 255 -> 0 at default).
REQ-023 SHALL have no combinational path from InValid or InData to any output.

Reset
REQ-024 SHALL, on Reset=1, immediately (without waiting for Clock) force both FSMs to EMPTY, Out0Valid=Out1Valid=0, Out0Data=Out1Data=0, Count0=Count1=0.
REQ-025 SHALL discard any buffered or in-flight word when Reset asserts mid-operation; no transfer counted in the reset cycle.
REQ-026 SHALL resume normal operation on the first rising edge after Reset deasserts; InReady=1 for either InSel immediately after reset.

Verification
REQ-027 Basic route: after reset, InValid=1, InSel=1, InData=24'hABCDEF, Out1Ready=0 -> next cycle Out1Valid=1, Out1Data=24'hABCDEF, Out0Valid=0; holds for 5 cycles until Out1Ready=1, then Count1=1, Out1Valid=0.
REQ-028 Backpressure: port 0 FULL with 24'h000001, Out0Ready=0, InSel=0, InValid=1 -> InReady=0, Out0Data stays 24'h000001; switching InSel=1 -> InReady=1 and word lands in port 1.
REQ-029 Streaming: Out0Ready=1 constant, InSel=0, InValid=1, data 1,2,3,...,10 on consecutive cycles -> InReady=1 every cycle, Out0Data 1..10 in order one per cycle, Count0=10.
REQ-030 Parallel ports: both buffers FULL, Out0Ready=Out1Ready=1 in same cycle -> both counters increment by 1, both Valid drop to 0.
REQ-031 Counter wrap: 256 transfers on port 1 -> Count1 returns to 0; Count0 unchanged.
REQ-032 Async reset mid-operation: both ports FULL, assert Reset between clock edges -> Out0Valid=Out1Valid=0 and counters 0 before next edge; first accept after deassert behaves as REQ-027.

Source files
------------

// File: rtl/demux1to2_buffered.sv
// demux1to2_buffered: routes one input word stream to one of two output ports,
// each port backed by a single-entry buffer with a valid/ready handshake and a
// running count of completed output transfers.
module demux1to2_buffered #(
    parameter int WIDTH = 24,
    parameter int CNTW  = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InData,
    input  logic             InSel,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Out0Data,
    output logic [WIDTH-1:0] Out1Data,
    output logic             Out0Valid,
    output logic             Out1Valid,
    input  logic             Out0Ready,
    input  logic             Out1Ready,
    output logic [CNTW-1:0]  Count0,
    output logic [CNTW-1:0]  Count1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bufState_e;

    bufState_e        state0_q, state0_d;
    bufState_e        state1_q, state1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [CNTW-1:0]  count0_q, count0_d;
    logic [CNTW-1:0]  count1_q, count1_d;

    logic accept;
    logic accept0;
    logic accept1;
    logic xfer0;
    logic xfer1;

    // Input readiness and handshake decode; InValid only qualifies accept, never InReady
    always_comb begin
        InReady = 1'b0;
        if (InSel) begin
            InReady = (state1_q == EMPTY) || Out1Ready;
        end else begin
            InReady = (state0_q == EMPTY) || Out0Ready;
        end
        accept  = InValid && InReady;
        accept0 = accept && !InSel;
        accept1 = accept && InSel;
        xfer0   = (state0_q == FULL) && Out0Ready;
        xfer1   = (state1_q == FULL) && Out1Ready;
    end

    // Port 0 buffer next state: load on accept (even while draining), empty on a lone transfer
    always_comb begin
        state0_d = state0_q;
        data0_d  = data0_q;
        count0_d = count0_q;
        if (xfer0) begin
            count0_d = count0_q + 1'b1;
        end
        case (state0_q)
            EMPTY: begin
                if (accept0) begin
                    state0_d = FULL;
                    data0_d  = InData;
                end
            end
            FULL: begin
                if (accept0) begin
                    data0_d = InData;
                end else if (xfer0) begin
                    state0_d = EMPTY;
                end
            end
            default: state0_d = EMPTY;
        endcase
    end

    // Port 1 buffer next state: same behaviour as port 0
    always_comb begin
        state1_d = state1_q;
        data1_d  = data1_q;
        count1_d = count1_q;
        if (xfer1) begin
            count1_d = count1_q + 1'b1;
        end
        case (state1_q)
            EMPTY: begin
                if (accept1) begin
                    state1_d = FULL;
                    data1_d  = InData;
                end
            end
            FULL: begin
                if (accept1) begin
                    data1_d = InData;
                end else if (xfer1) begin
                    state1_d = EMPTY;
                end
            end
            default: state1_d = EMPTY;
        endcase
    end

    // State, data and counter registers; reset clears everything without waiting for a clock
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state0_q <= EMPTY;
            state1_q <= EMPTY;
            data0_q  <= '0;
            data1_q  <= '0;
            count0_q <= '0;
            count1_q <= '0;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            count0_q <= count0_d;
            count1_q <= count1_d;
        end
    end

    assign Out0Data  = data0_q;
    assign Out1Data  = data1_q;
    assign Out0Valid = (state0_q == FULL);
    assign Out1Valid = (state1_q == FULL);
    assign Count0    = count0_q;
    assign Count1    = count1_q;

endmodule

// File: tb/tb_demux1to2_buffered.sv
// tb_demux1to2_buffered: directed checks of routing, backpressure, streaming,
// parallel drain, counter wrap and asynchronous reset.
module tb_demux1to2_buffered;

    localparam int WIDTH = 24;
    localparam int CNTW  = 8;

    logic             Clock;
    logic             Reset;
    logic [WIDTH-1:0] InData;
    logic             InSel;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] Out0Data;
    logic [WIDTH-1:0] Out1Data;
    logic             Out0Valid;
    logic             Out1Valid;
    logic             Out0Ready;
    logic             Out1Ready;
    logic [CNTW-1:0]  Count0;
    logic [CNTW-1:0]  Count1;

    int compared;
    int mismatched;

    demux1to2_buffered #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InData   (InData),
        .InSel    (InSel),
        .InValid  (InValid),
        .InReady  (InReady),
        .Out0Data (Out0Data),
        .Out1Data (Out1Data),
        .Out0Valid(Out0Valid),
        .Out1Valid(Out1Valid),
        .Out0Ready(Out0Ready),
        .Out1Ready(Out1Ready),
        .Count0   (Count0),
        .Count1   (Count1)
    );

    // Free-running clock, 10 time-unit period
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the input side of the block
    task automatic applyStimulus(input logic valid, input logic sel, input logic [WIDTH-1:0] data);
        InValid = valid;
        InSel   = sel;
        InData  = data;
    endtask

    // Directed sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        Reset      = 1'b1;
        Out0Ready  = 1'b0;
        Out1Ready  = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        #3;
        checkOutput("rst_out0valid", 32'(Out0Valid), 32'd0);
        checkOutput("rst_out1valid", 32'(Out1Valid), 32'd0);
        checkOutput("rst_out0data", 32'(Out0Data), 32'd0);
        checkOutput("rst_out1data", 32'(Out1Data), 32'd0);
        checkOutput("rst_count0", 32'(Count0), 32'd0);
        checkOutput("rst_count1", 32'(Count1), 32'd0);
        step();
        step();
        Reset = 1'b0;
        step();
        checkOutput("rst_inready_sel0", 32'(InReady), 32'd1);
        InSel = 1'b1;
        #1;
        checkOutput("rst_inready_sel1", 32'(InReady), 32'd1);

        // Basic route to port 1 and hold under backpressure
        applyStimulus(1'b1, 1'b1, 24'hABCDEF);
        #1;
        checkOutput("route_inready", 32'(InReady), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 24'h123456);
        checkOutput("route_out1valid", 32'(Out1Valid), 32'd1);
        checkOutput("route_out1data", 32'(Out1Data), 32'hABCDEF);
        checkOutput("route_out0valid", 32'(Out0Valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("hold_out1valid", 32'(Out1Valid), 32'd1);
            checkOutput("hold_out1data", 32'(Out1Data), 32'hABCDEF);
            checkOutput("hold_count1", 32'(Count1), 32'd0);
        end
        Out1Ready = 1'b1;
        step();
        Out1Ready = 1'b0;
        checkOutput("route_count1", 32'(Count1), 32'd1);
        checkOutput("route_out1valid_drop", 32'(Out1Valid), 32'd0);
        checkOutput("route_out1data_kept", 32'(Out1Data), 32'hABCDEF);

        // Backpressure on port 0 while port 1 stays open
        applyStimulus(1'b1, 1'b0, 24'h000001);
        step();
        applyStimulus(1'b1, 1'b0, 24'h000002);
        #1;
        checkOutput("bp_inready_sel0", 32'(InReady), 32'd0);
        step();
        checkOutput("bp_out0data", 32'(Out0Data), 32'h000001);
        checkOutput("bp_out0valid", 32'(Out0Valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 24'h000003);
        #1;
        checkOutput("bp_inready_sel1", 32'(InReady), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("bp_out1valid", 32'(Out1Valid), 32'd1);
        checkOutput("bp_out1data", 32'(Out1Data), 32'h000003);
        checkOutput("bp_out0data_stays", 32'(Out0Data), 32'h000001);

        // Both ports full, drained in the same cycle
        Out0Ready = 1'b1;
        Out1Ready = 1'b1;
        step();
        Out0Ready = 1'b0;
        Out1Ready = 1'b0;
        checkOutput("par_count0", 32'(Count0), 32'd1);
        checkOutput("par_count1", 32'(Count1), 32'd2);
        checkOutput("par_out0valid", 32'(Out0Valid), 32'd0);
        checkOutput("par_out1valid", 32'(Out1Valid), 32'd0);

        // Streaming ten words through port 0 with no bubbles
        Out0Ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, WIDTH'(i));
            #1;
            checkOutput("stream_inready", 32'(InReady), 32'd1);
            step();
            checkOutput("stream_out0data", 32'(Out0Data), 32'(i));
            checkOutput("stream_out0valid", 32'(Out0Valid), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, '0);
        step();
        Out0Ready = 1'b0;
        checkOutput("stream_out0valid_end", 32'(Out0Valid), 32'd0);
        checkOutput("stream_count0", 32'(Count0), 32'd11);

        // 256 transfers on port 1: counter passes through zero and returns to start
        Out1Ready = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            applyStimulus(1'b1, 1'b1, WIDTH'(k));
            step();
            if (k == 255) begin
                checkOutput("wrap_count1_zero", 32'(Count1), 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, '0);
        step();
        Out1Ready = 1'b0;
        checkOutput("wrap_count1_final", 32'(Count1), 32'd2);
        checkOutput("wrap_count0_same", 32'(Count0), 32'd11);
        checkOutput("wrap_out1valid", 32'(Out1Valid), 32'd0);

        // Asynchronous reset between clock edges with both ports full
        applyStimulus(1'b1, 1'b0, 24'h000005);
        step();
        applyStimulus(1'b1, 1'b1, 24'h000006);
        step();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("ar_pre_out0valid", 32'(Out0Valid), 32'd1);
        checkOutput("ar_pre_out1valid", 32'(Out1Valid), 32'd1);
        Out0Ready = 1'b1;
        Out1Ready = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("ar_out0valid", 32'(Out0Valid), 32'd0);
        checkOutput("ar_out1valid", 32'(Out1Valid), 32'd0);
        checkOutput("ar_count0", 32'(Count0), 32'd0);
        checkOutput("ar_count1", 32'(Count1), 32'd0);
        checkOutput("ar_out0data", 32'(Out0Data), 32'd0);
        step();
        checkOutput("ar_count1_in_reset", 32'(Count1), 32'd0);
        Out0Ready = 1'b0;
        Out1Ready = 1'b0;
        Reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 24'hABCDEF);
        #1;
        checkOutput("ar_inready", 32'(InReady), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("ar_route_out1valid", 32'(Out1Valid), 32'd1);
        checkOutput("ar_route_out1data", 32'(Out1Data), 32'hABCDEF);
        checkOutput("ar_route_out0valid", 32'(Out0Valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
